// File: rtl/k12a_lcd_responder_pkg.sv
// rtl/k12a_lcd_responder_pkg.sv - shared types, constants and DDRAM address helpers for the LCD responder
package k12a_lcd_responder_pkg;

   typedef enum logic [1:0] {
      LCD_IDLE,
      LCD_BUSY,
      LCD_CLEARING
   } lcd_state_t;

   localparam int         LCD_LINE_LEN   = 40;
   localparam int         LCD_DDRAM_SIZE = 80;
   localparam logic [6:0] LCD_LINE1_BASE = 7'h40;
   localparam logic [6:0] LCD_LINE0_LAST = 7'h27;
   localparam logic [6:0] LCD_LINE1_LAST = 7'h67;
   localparam logic [7:0] LCD_BLANK_CHAR = 8'h20;

   // Instruction decode uses the position of the highest set bit.
   localparam int LCD_OP_CLEAR_BIT   = 0;
   localparam int LCD_OP_HOME_BIT    = 1;
   localparam int LCD_OP_ENTRY_BIT   = 2;
   localparam int LCD_OP_DISPLAY_BIT = 3;
   localparam int LCD_OP_SET_DD_BIT  = 7;

   function automatic logic lcd_addr_valid(input logic [6:0] a);
      return a[5:0] <= LCD_LINE0_LAST[5:0];
   endfunction

   // Packs the two 40-byte lines back to back in the 80-entry array.
   function automatic logic [6:0] lcd_addr_index(input logic [6:0] a);
      return a[6] ? 7'(LCD_LINE_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
   endfunction

endpackage

// File: rtl/k12a_lcd_ac_step.sv
// rtl/k12a_lcd_ac_step.sv - next DDRAM address with line wrap, shared by AC stepping and the clear walk
module k12a_lcd_ac_step
   import k12a_lcd_responder_pkg::*;
(
   input  logic [6:0] ac,
   input  logic       inc,
   output logic [6:0] ac_next
);

   always_comb begin
      ac_next = ac;
      if (inc) begin
         if (ac == LCD_LINE0_LAST)      ac_next = LCD_LINE1_BASE;
         else if (ac == LCD_LINE1_LAST) ac_next = 7'h00;
         else                           ac_next = ac + 7'd1;
      end else begin
         if (ac == 7'h00)               ac_next = LCD_LINE1_LAST;
         else if (ac == LCD_LINE1_BASE) ac_next = LCD_LINE0_LAST;
         else                           ac_next = ac - 7'd1;
      end
   end

endmodule

// File: rtl/k12a_lcd_responder.sv
// rtl/k12a_lcd_responder.sv - HD44780-subset panel-side responder with DDRAM, AC, busy flag and view port
module k12a_lcd_responder
   import k12a_lcd_responder_pkg::*;
#(
   parameter int BUSY_CYCLES      = 40,
   parameter int BUSY_LONG_CYCLES = 160
) (
   input  logic       sys_clock,
   input  logic       reset,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_en,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   input  logic [6:0] view_addr,
   output logic [7:0] view_char,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       busy,
   output logic       cmd_dropped
);

   localparam logic [15:0] CNT_SHORT  = 16'(BUSY_CYCLES - 1);
   localparam logic [15:0] CNT_LONG   = 16'(BUSY_LONG_CYCLES - 1);
   localparam logic [15:0] CNT_CLEAR  = 16'(BUSY_LONG_CYCLES - 81);
   localparam bit          CLEAR_TAIL = BUSY_LONG_CYCLES > 80;

   logic       en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_s3_q, en_s3_d;
   logic       rs_s1_q, rs_s1_d, rs_s2_q, rs_s2_d;
   logic       rw_s1_q, rw_s1_d, rw_s2_q, rw_s2_d;
   logic [7:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   lcd_state_t state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [6:0] ac_q, ac_d, walk_q, walk_d, clr_cnt_q, clr_cnt_d;
   logic       id_q, id_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic       drop_q, drop_d, oe_q, oe_d;
   logic [7:0] data_out_q, data_out_d, view_q, view_d;

   logic [7:0] ddram [LCD_DDRAM_SIZE];
   logic       mem_we;
   logic [6:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic [6:0] ac_next, walk_next, ac_idx, view_idx;
   logic       bf, commit, view_ok;

   k12a_lcd_ac_step u_ac_step   (.ac(ac_q),   .inc(id_q), .ac_next(ac_next));
   k12a_lcd_ac_step u_walk_step (.ac(walk_q), .inc(1'b1), .ac_next(walk_next));

   assign bf       = (state_q != LCD_IDLE);
   assign commit   = en_s3_q & ~en_s2_q;
   assign ac_idx   = lcd_addr_index(ac_q);
   assign view_ok  = lcd_addr_valid(view_addr);
   assign view_idx = view_ok ? lcd_addr_index(view_addr) : 7'd0;

   always_comb begin
      en_s1_d   = lcd_en;
      en_s2_d   = en_s1_q;
      en_s3_d   = en_s2_q;
      rs_s1_d   = lcd_rs;
      rs_s2_d   = rs_s1_q;
      rw_s1_d   = lcd_rw;
      rw_s2_d   = rw_s1_q;
      data_s1_d = lcd_data_in;
      data_s2_d = data_s1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      ac_d      = ac_q;
      id_d      = id_q;
      disp_d    = disp_q;
      cur_d     = cur_q;
      blink_d   = blink_q;
      drop_d    = drop_q;
      walk_d    = walk_q;
      clr_cnt_d = clr_cnt_q;
      oe_d      = en_s2_q & rw_s2_q;
      data_out_d = data_out_q;
      mem_we    = 1'b0;
      mem_waddr = ac_idx;
      mem_wdata = data_s2_q;
      view_d    = view_ok ? ddram[view_idx] : 8'h00;

      if (en_s2_q && rw_s2_q)
         data_out_d = rs_s2_q ? ddram[ac_idx] : {bf, ac_q};

      unique case (state_q)
         LCD_BUSY: begin
            if (cnt_q == 16'd0) state_d = LCD_IDLE;
            else                cnt_d   = cnt_q - 16'd1;
         end
         LCD_CLEARING: begin
            mem_we    = 1'b1;
            mem_waddr = lcd_addr_index(walk_q);
            mem_wdata = LCD_BLANK_CHAR;
            walk_d    = walk_next;
            clr_cnt_d = clr_cnt_q + 7'd1;
            if (clr_cnt_q == 7'(LCD_DDRAM_SIZE - 1)) begin
               ac_d    = 7'h00;
               id_d    = 1'b1;
               state_d = CLEAR_TAIL ? LCD_BUSY : LCD_IDLE;
               cnt_d   = CNT_CLEAR;
            end
         end
         default: ;
      endcase

      if (commit) begin
         if (rw_s2_q) begin
            if (rs_s2_q) begin
               if (bf) drop_d = 1'b1;
               else    ac_d   = ac_next;
            end
         end else if (bf) begin
            drop_d = 1'b1;
         end else if (rs_s2_q) begin
            mem_we  = 1'b1;
            ac_d    = ac_next;
            state_d = LCD_BUSY;
            cnt_d   = CNT_SHORT;
         end else begin
            state_d = LCD_BUSY;
            cnt_d   = CNT_SHORT;
            if (data_s2_q[LCD_OP_SET_DD_BIT]) begin
               if (lcd_addr_valid(data_s2_q[6:0])) begin
                  ac_d = data_s2_q[6:0];
               end else begin
                  drop_d  = 1'b1;
                  state_d = state_q;
                  cnt_d   = cnt_q;
               end
            end else if (data_s2_q[6:4] != 3'b000) begin
               // Shift/function-set/CGRAM commands only cost busy time here.
            end else if (data_s2_q[LCD_OP_DISPLAY_BIT]) begin
               disp_d  = data_s2_q[2];
               cur_d   = data_s2_q[1];
               blink_d = data_s2_q[0];
            end else if (data_s2_q[LCD_OP_ENTRY_BIT]) begin
               id_d = data_s2_q[1];
            end else if (data_s2_q[LCD_OP_HOME_BIT]) begin
               ac_d  = 7'h00;
               cnt_d = CNT_LONG;
            end else if (data_s2_q[LCD_OP_CLEAR_BIT]) begin
               state_d   = LCD_CLEARING;
               walk_d    = 7'h00;
               clr_cnt_d = 7'd0;
            end
         end
      end
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         en_s1_q    <= 1'b0;
         en_s2_q    <= 1'b0;
         en_s3_q    <= 1'b0;
         rs_s1_q    <= 1'b0;
         rs_s2_q    <= 1'b0;
         rw_s1_q    <= 1'b0;
         rw_s2_q    <= 1'b0;
         data_s1_q  <= 8'h00;
         data_s2_q  <= 8'h00;
         state_q    <= LCD_IDLE;
         cnt_q      <= 16'd0;
         ac_q       <= 7'h00;
         id_q       <= 1'b1;
         disp_q     <= 1'b0;
         cur_q      <= 1'b0;
         blink_q    <= 1'b0;
         drop_q     <= 1'b0;
         walk_q     <= 7'h00;
         clr_cnt_q  <= 7'd0;
         oe_q       <= 1'b0;
         data_out_q <= 8'h00;
         view_q     <= 8'h00;
      end else begin
         en_s1_q    <= en_s1_d;
         en_s2_q    <= en_s2_d;
         en_s3_q    <= en_s3_d;
         rs_s1_q    <= rs_s1_d;
         rs_s2_q    <= rs_s2_d;
         rw_s1_q    <= rw_s1_d;
         rw_s2_q    <= rw_s2_d;
         data_s1_q  <= data_s1_d;
         data_s2_q  <= data_s2_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ac_q       <= ac_d;
         id_q       <= id_d;
         disp_q     <= disp_d;
         cur_q      <= cur_d;
         blink_q    <= blink_d;
         drop_q     <= drop_d;
         walk_q     <= walk_d;
         clr_cnt_q  <= clr_cnt_d;
         oe_q       <= oe_d;
         data_out_q <= data_out_d;
         view_q     <= view_d;
      end
   end

   // DDRAM has no reset so an aborted clear leaves untouched cells intact.
   always_ff @(posedge sys_clock) begin
      if (mem_we) ddram[mem_waddr] <= mem_wdata;
   end

   assign lcd_data_out = data_out_q;
   assign lcd_data_oe  = oe_q;
   assign view_char    = view_q;
   assign display_on   = disp_q;
   assign cursor_on    = cur_q;
   assign blink_on     = blink_q;
   assign busy         = bf;
   assign cmd_dropped  = drop_q;

endmodule

// File: tb/tb_k12a_lcd_responder.sv
// tb/tb_k12a_lcd_responder.sv - randomized self-checking bench for k12a_lcd_responder against a behavioural model
module tb_k12a_lcd_responder;

   localparam int BC = 40;
   localparam int BL = 160;

   logic       sys_clock = 1'b0;
   logic       reset = 1'b1;
   logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
   logic [7:0] lcd_data_in = 8'h00;
   logic [6:0] view_addr = 7'h00;
   logic [7:0] lcd_data_out, view_char;
   logic       lcd_data_oe, display_on, cursor_on, blink_on, busy, cmd_dropped;

   k12a_lcd_responder #(.BUSY_CYCLES(BC), .BUSY_LONG_CYCLES(BL)) dut (
      .sys_clock(sys_clock), .reset(reset),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
      .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
      .view_addr(view_addr), .view_char(view_char),
      .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .busy(busy), .cmd_dropped(cmd_dropped)
   );

   always #5 sys_clock = ~sys_clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Address-keyed model of the panel
   logic [7:0] mm [0:127];
   bit         known [0:127];
   logic [6:0] m_ac = 7'h00;
   bit         m_id = 1'b1;
   bit         m_disp = 0, m_cur = 0, m_blink = 0, m_drop = 0;

   function automatic bit m_valid(input logic [6:0] a);
      return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
   endfunction

   function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
      int pos;
      pos = (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
      pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
      return (pos < 40) ? 7'(pos) : 7'(pos - 40 + 64);
   endfunction

   task automatic model_clear();
      for (int a = 0; a < 128; a++)
         if (m_valid(7'(a))) begin mm[a] = 8'h20; known[a] = 1; end
      m_ac = 7'h00;
      m_id = 1'b1;
   endtask

   task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d, input bit busy_now,
                              output logic [7:0] exp_rd, output bit rd_known, output int exp_busy);
      exp_busy = 0; rd_known = 1; exp_rd = 8'h00;
      if (rw) begin
         if (!rs) exp_rd = {busy_now, m_ac};
         else begin
            exp_rd = mm[m_ac]; rd_known = known[m_ac];
            if (busy_now) m_drop = 1; else m_ac = m_step(m_ac, m_id);
         end
      end else if (busy_now) m_drop = 1;
      else if (rs) begin
         mm[m_ac] = d; known[m_ac] = 1; m_ac = m_step(m_ac, m_id); exp_busy = BC;
      end else if (d >= 8'h80) begin
         if (m_valid(d[6:0])) begin m_ac = d[6:0]; exp_busy = BC; end
         else m_drop = 1;
      end else if (d >= 8'h10) exp_busy = BC;
      else if (d >= 8'h08) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; exp_busy = BC; end
      else if (d >= 8'h04) begin m_id = d[1]; exp_busy = BC; end
      else if (d >= 8'h02) begin m_ac = 7'h00; exp_busy = BL; end
      else if (d == 8'h01) begin model_clear(); exp_busy = BL; end
      else exp_busy = BC;
   endtask

   task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input bit wait_idle, input bit busy_now);
      logic [7:0] exp_rd;
      bit         rk;
      int         exp_busy, n;
      model_apply(rs, rw, d, busy_now, exp_rd, rk, exp_busy);
      @(posedge sys_clock);
      #3 lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
      #1 lcd_en = 1'b1;
      repeat (6) @(negedge sys_clock);
      check("oe_during", lcd_data_oe, rw);
      if (rw && rk && rs)  check("rd_data", lcd_data_out, exp_rd);
      if (rw && !rs)       check("rd_bf_ac", lcd_data_out, exp_rd);
      lcd_en = 1'b0;
      n = 0;
      for (int i = 0; i < BL + 40; i++) begin
         @(negedge sys_clock);
         if (i == 2) begin
            check("oe_drop", lcd_data_oe, 0);
            if (!wait_idle) break;
         end
         if (i == 4) begin lcd_data_in = 8'($urandom); lcd_rs = 1'($urandom); lcd_rw = 1'($urandom); end
         if (busy) n++;
         else if (n > 0 || i >= 6) break;
      end
      if (wait_idle) begin
         check("busy_len", n, exp_busy);
         check("dropped", cmd_dropped, m_drop);
         check("disp_bits", {display_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
      end
   endtask

   task automatic view_check(input logic [6:0] a);
      @(negedge sys_clock) view_addr = a;
      @(negedge sys_clock);
      if (known[a]) check("view", view_char, mm[a]);
   endtask

   task automatic sweep();
      for (int a = 0; a < 128; a++)
         if (m_valid(7'(a))) view_check(7'(a));
   endtask

   task automatic wait_idle_bounded();
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge sys_clock);
         if (!busy) break;
      end
      check("idle_timeout", k < 400, 1);
   endtask

   logic [7:0] saved [0:127];
   int         r;

   initial begin
      for (int a = 0; a < 128; a++) begin mm[a] = 8'h00; known[a] = 0; end
      repeat (3) @(negedge sys_clock);
      check("rst_busy", busy, 0);
      check("rst_oe", lcd_data_oe, 0);
      check("rst_dout", lcd_data_out, 8'h00);
      check("rst_view", view_char, 8'h00);
      check("rst_disp", {display_on, cursor_on, blink_on}, 3'b000);
      check("rst_drop", cmd_dropped, 0);
      reset = 1'b0;
      repeat (2) @(negedge sys_clock);

      xfer(0, 1, 8'h00, 1, 0);
      xfer(0, 0, 8'hA7, 1, 0);
      xfer(0, 0, 8'h06, 1, 0);
      xfer(1, 0, 8'h41, 1, 0);
      view_check(7'h27);
      xfer(0, 1, 8'h00, 1, 0);

      xfer(0, 0, 8'h04, 1, 0);
      xfer(0, 0, 8'h80, 1, 0);
      xfer(1, 0, 8'h5A, 1, 0);
      xfer(0, 1, 8'h00, 1, 0);
      view_check(7'h00);

      xfer(0, 0, 8'h01, 1, 0);
      sweep();
      xfer(0, 1, 8'h00, 1, 0);

      xfer(0, 0, 8'h02, 0, 0);
      xfer(0, 0, 8'h0F, 0, 1);
      wait_idle_bounded();
      check("drop_busy_wr", cmd_dropped, 1);
      check("disp_unchanged", display_on, 0);
      xfer(0, 0, 8'h0F, 1, 0);

      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: xfer(1, 0, 8'($urandom_range(8'h20, 8'h7E)), 1, 0);
            3:       xfer(1, 1, 8'h00, 1, 0);
            4:       xfer(0, 1, 8'h00, 1, 0);
            5:       xfer(0, 0, 8'h04 | 8'($urandom_range(0, 3)), 1, 0);
            6:       xfer(0, 0, 8'h08 | 8'($urandom_range(0, 7)), 1, 0);
            7:       xfer(0, 0, 8'h80 | 8'($urandom_range(0, 127)), 1, 0);
            8:       if ($urandom_range(0, 1) == 0) xfer(0, 0, 8'h02 | 8'($urandom_range(0, 1)), 1, 0);
                     else xfer(0, 0, 8'($urandom_range(8'h10, 8'h3F)), 1, 0);
            default: if ($urandom_range(0, 7) == 0) xfer(0, 0, 8'h01, 1, 0);
                     else xfer(0, 0, 8'h80 | (8'($urandom_range(0, 1)) << 6) | 8'($urandom_range(0, 39)), 1, 0);
         endcase
      end
      sweep();

      xfer(0, 0, 8'h88, 1, 0);
      xfer(0, 0, 8'h06, 1, 0);
      for (int i = 0; i < 8; i++) xfer(1, 0, 8'h61 + 8'(i), 1, 0);
      for (int a = 0; a < 128; a++) saved[a] = mm[a];
      xfer(0, 0, 8'h01, 0, 0);
      repeat (10) @(negedge sys_clock);
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_oe", lcd_data_oe, 0);
      check("abort_drop", cmd_dropped, 0);
      for (int a = 0; a < 128; a++) mm[a] = saved[a];
      for (int a = 0; a < 10; a++) mm[a] = 8'h20;
      m_ac = 7'h00; m_id = 1'b1; m_disp = 0; m_cur = 0; m_blink = 0; m_drop = 0;
      @(negedge sys_clock) reset = 1'b0;
      sweep();
      xfer(0, 1, 8'h00, 1, 0);
      xfer(1, 0, 8'h33, 1, 0);
      xfer(0, 1, 8'h00, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
